partoserial_lane_sched: RTL and testbench
=========================================

// Module: partoserial_lane_sched
// PURPOSE
//  Transmit scheduler for the parallel-to-serial lane. Shares one serial lane between NUM_REQ byte
//  requesters: sequences 8-bit frames on clk_8f, picks one requester per frame (round-robin),
//  shifts the byte out MSB first and fills empty frames with the idle symbol.
//  Sits in front of the lane; the downstream serial-to-parallel side aligns on IDLE_SYM.
// PARAMETERS
//  NUM_REQ       4      number of byte requesters (2..8)
//  IDLE_SYM      8'hBC  symbol sent in every frame with no data (valid_out=0)
//  TRAIN_FRAMES  2      idle-only frames forced after reset release before any grant (>=1)
// PORTS
//  clk_8f      in   1          bit clock; one serial bit per rising edge
//  reset       in   1          asynchronous, active-low; 0 = in reset
//  req         in   NUM_REQ    req[i]=1: requester i holds a valid byte
//  data_in     in   8*NUM_REQ  byte of requester i on data_in[8*i+7:8*i]; stable while req[i]=1
//  ack         out  NUM_REQ    one-cycle pulse: byte of requester i taken this frame
//  data_out    out  1          serial bit, MSB of the frame byte first
//  valid_out   out  1          1 for the whole frame when it carries requester data
//  frame_start out  1          1 during bit 0 (MSB) of every frame
//  lane_id     out  clog2(NUM_REQ)  requester owning the current frame (held when idle)
// BEHAVIOUR
//  - Reset (async): ph=7, shreg=0, state=TRAIN, frame_cnt=0, rr_ptr=NUM_REQ-1;
//    data_out=0, valid_out=0, ack=0, frame_start=0, lane_id=0.
//  - ph: 3-bit bit counter, +1 every clk_8f edge, wraps 7->0. Edge where ph==7 = frame boundary.
//  - data_out = shreg[7]; shreg shifts left (LSB fills 0) each edge with ph!=7.
//  - At a frame boundary the frame byte is loaded into shreg; ph goes 0; frame_start=1 while ph==0.
//  - States: TRAIN -> ACTIVE. TRAIN: every frame loads IDLE_SYM, valid_out=0, req ignored, ack=0;
//    frame_cnt counts loaded frames; at the boundary loading frame TRAIN_FRAMES (frame_cnt reaches
//    TRAIN_FRAMES) state goes ACTIVE, so first grant is in frame TRAIN_FRAMES+1.
//    ACTIVE: arbitrate at each boundary. ACTIVE left only via reset.
//  - Arbitration (ACTIVE, at boundary edge): sample req; search order rr_ptr+1, rr_ptr+2, ... mod
//    NUM_REQ; first set bit i wins: shreg<=data_in[i], valid_out<=1, lane_id<=i, ack[i]<=1,
//    rr_ptr<=i. No req set: shreg<=IDLE_SYM, valid_out<=0, rr_ptr and lane_id unchanged.
//  - ack is registered: high exactly during the ph==0 cycle of the granted frame; at most one bit set.
//    Requester advances data_in/req on the edge it sees ack; a byte is never taken twice.
//  - Latency: req[i] rising while ph=k, lane otherwise idle -> MSB on data_out 8-k cycles later
//    (load at next boundary); 8 cycles per byte, back-to-back frames with no gap.
//  - req dropped before the boundary: not granted, nothing sent. req rising on the boundary edge itself
//    is not seen until the next boundary.
//  - All NUM_REQ requesting continuously: strict rotation 0,1,..,NUM_REQ-1,0,...
//  - Same requester alone requesting: granted every frame (no forced idle gap).
//  - Reset mid-frame: frame aborted immediately, outputs to reset values, TRAIN restarts.
//  - valid_out, lane_id change only at frame boundaries.
// STRUCTURE
//  - partoserial_defs.vh (shared): IDLE_SYM default 8'hBC, state encodings ST_TRAIN/ST_ACTIVE,
//    frame length constant FRAME_BITS=8; also included by the serial-to-parallel receiver.
//  - Sub-module rr_arbiter (NUM_REQ): combinational req + rr_ptr -> one-hot grant, index, any;
//    pointer register kept in partoserial_lane_sched.
//  - Top holds ph, frame_cnt, state, shreg, output registers.
// TESTING
//  1 Reset: reset=0 mid-frame with req=4'b1111 -> all outputs 0 asynchronously; release ->
//    frames 1..2 are 8'hBC serial (1011_1100), valid_out=0, no ack.
//  2 Single requester: after TRAIN, req=4'b0001, byte 8'h01 -> ack[0] one cycle at ph==0,
//    data_out 0000_0001, valid_out=1, lane_id=0; increment byte on ack -> 8'h02 next frame, no gap.
//  3 Round-robin: req=4'b1111, data 8'hA0/8'hA1/8'hA2/8'hA3 -> frame order A0,A1,A2,A3,A0;
//    exactly one ack per frame.
//  4 Idle fill: req=0 for 3 frames after traffic -> 3 frames 8'hBC, valid_out=0, lane_id held.
//  5 Late request: req[2] rises at ph=3 -> MSB of its byte appears 5 cycles later; req[1] pulsed
//    ph=2..5 and dropped -> never acked, never sent.
//  6 Mixed: req=4'b0101 steady -> alternation lane 0,2,0,2; drop req[0] -> lane 2 every frame.

Source files
------------

// File: rtl/partoserial_lane_sched_pkg.sv
// Shared definitions for the parallel-to-serial lane scheduler and its receiver.
package partoserial_lane_sched_pkg;

  // Bits per serial frame; one byte per frame.
  localparam int FRAME_BITS = 8;

  // Symbol sent in every frame that carries no requester data.
  localparam logic [FRAME_BITS-1:0] IDLE_SYM_DEF = 8'hBC;

  // Scheduler states: idle-only training after reset, then arbitrated traffic.
  typedef enum logic {
    ST_TRAIN  = 1'b0,
    ST_ACTIVE = 1'b1
  } lane_state_e;

endpackage

// File: rtl/partoserial_lane_sched_if.sv
// Requester-side bus and serial lane outputs of the lane scheduler.
//
// Handshake: req[i]=1 means requester i presents a valid byte on its data_in
// slice and keeps it stable while req[i] is high. ack[i] is a one-cycle pulse
// during the first bit of the frame that carries the byte; the requester
// advances its byte (or drops req[i]) on the edge that samples ack[i]=1.
// A request dropped before the frame boundary is never taken.
interface partoserial_lane_sched_if #(
  parameter int NUM_REQ = 4
);
  import partoserial_lane_sched_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [FRAME_BITS*NUM_REQ-1:0] data_in;
  logic [NUM_REQ-1:0]            ack;
  logic                          data_out;
  logic                          valid_out;
  logic                          frame_start;
  logic [IDX_W-1:0]              lane_id;
  lane_state_e                   state_dbg;

  modport slave (
    input  req, data_in,
    output ack, data_out, valid_out, frame_start, lane_id, state_dbg
  );

  modport master (
    output req, data_in,
    input  ack, data_out, valid_out, frame_start, lane_id, state_dbg
  );

endinterface

// File: rtl/partoserial_lane_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr_i (wrapping) wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Scan ptr+1, ptr+2, ... modulo NUM_REQ and keep the first set request.
  always_comb begin
    int unsigned cand;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(ptr_i) + off) % NUM_REQ;
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = IDX_W'(cand);
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/partoserial_lane_sched.sv
// Transmit scheduler: shares one serial lane between NUM_REQ byte requesters,
// one round-robin grant per 8-bit frame, MSB first, idle symbol when empty.
module partoserial_lane_sched
  import partoserial_lane_sched_pkg::*;
#(
  parameter int                    NUM_REQ      = 4,
  parameter logic [FRAME_BITS-1:0] IDLE_SYM     = IDLE_SYM_DEF,
  parameter int                    TRAIN_FRAMES = 2
) (
  input  logic                    clk_8f,
  input  logic                    reset,
  partoserial_lane_sched_if.slave bus
);

  localparam int                 IDX_W       = $clog2(NUM_REQ);
  localparam int                 PH_W        = $clog2(FRAME_BITS);
  localparam int                 CNT_W       = $clog2(TRAIN_FRAMES + 1);
  localparam logic [PH_W-1:0]    PH_LAST     = PH_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0]   PTR_RST     = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   TRAIN_LAST1 = CNT_W'(TRAIN_FRAMES - 1);

  logic [PH_W-1:0]       ph_q, ph_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  lane_state_e           state_q, state_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      lane_q, lane_d;
  logic                  valid_q, valid_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;

  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_any;
  logic                  boundary;

  // The edge that ends bit 7 loads the next frame.
  assign boundary = (ph_q == PH_LAST);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (bus.req),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  // Next-state: bit shifting every edge, frame load and arbitration at the boundary.
  always_comb begin
    ph_d        = ph_q + PH_W'(1);
    shreg_d     = {shreg_q[FRAME_BITS-2:0], 1'b0};
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    lane_d      = lane_q;
    valid_d     = valid_q;
    ack_d       = '0;
    if (boundary) begin
      unique case (state_q)
        ST_TRAIN: begin
          // Requests are ignored; the receiver aligns on the idle symbol.
          shreg_d     = IDLE_SYM;
          valid_d     = 1'b0;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          if (frame_cnt_q == TRAIN_LAST1) begin
            state_d = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (grant_any) begin
            shreg_d  = bus.data_in[FRAME_BITS*grant_idx +: FRAME_BITS];
            valid_d  = 1'b1;
            lane_d   = grant_idx;
            rr_ptr_d = grant_idx;
            ack_d    = grant;
          end else begin
            // Empty frame: pointer and lane id keep their last grant.
            shreg_d = IDLE_SYM;
            valid_d = 1'b0;
          end
        end
      endcase
    end
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      ph_q        <= PH_LAST;
      shreg_q     <= '0;
      state_q     <= ST_TRAIN;
      frame_cnt_q <= '0;
      rr_ptr_q    <= PTR_RST;
      lane_q      <= '0;
      valid_q     <= 1'b0;
      ack_q       <= '0;
    end else begin
      ph_q        <= ph_d;
      shreg_q     <= shreg_d;
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      lane_q      <= lane_d;
      valid_q     <= valid_d;
      ack_q       <= ack_d;
    end
  end

  assign bus.data_out    = shreg_q[FRAME_BITS-1];
  assign bus.frame_start = (ph_q == '0);
  assign bus.valid_out   = valid_q;
  assign bus.lane_id     = lane_q;
  assign bus.ack         = ack_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_partoserial_lane_sched.sv
// Bench for partoserial_lane_sched: frame-level reference model, per-cycle
// output comparison, frame scoreboard and directed literal scenarios.
module tb_partoserial_lane_sched;
  import partoserial_lane_sched_pkg::*;

  localparam int          N           = 4;
  localparam int          TF          = 2;
  localparam logic [7:0]  IDLE        = 8'hBC;
  localparam int          RAND_CYCLES = 4000;

  // ---------------- clock / reset ----------------
  logic clk_8f = 1'b0;
  logic reset  = 1'b0;
  always #5 clk_8f = ~clk_8f;

  partoserial_lane_sched_if #(.NUM_REQ(N)) bus ();

  partoserial_lane_sched #(
    .NUM_REQ      (N),
    .IDLE_SYM     (IDLE),
    .TRAIN_FRAMES (TF)
  ) dut (
    .clk_8f (clk_8f),
    .reset  (reset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (frame level) ----------------
  bit          in_reset = 1'b1;
  int          t        = 0;      // rising edges since reset release
  int          frame_no = 0;      // frames loaded since reset release
  logic [7:0]  m_byte   = 8'h00;
  bit          m_valid  = 1'b0;
  int          m_lane   = 0;
  int          m_ptr    = N - 1;
  logic [10:0] exp_q[$];          // {lane, byte} of granted frames not yet seen

  // ---------------- requesters ----------------
  logic [7:0] r_byte   [N];
  int         r_left   [N];
  int         r_delta  [N];       // -1: random next byte
  int         ack_seen [N];

  // ---------------- frame capture ----------------
  int         cap_n = -1;
  logic [7:0] cap_byte;
  bit         cap_valid;
  int         cap_lane;
  logic [7:0] log_byte[$];
  bit         log_valid[$];
  int         log_lane[$];

  bit         lit_valid[$];
  int         lit_lane[$];
  logic [7:0] lit_byte[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic start_req(input int i, input logic [7:0] b, input int cnt, input int delta);
    r_byte[i]  = b;
    r_left[i]  = cnt;
    r_delta[i] = delta;
    bus.data_in[8*i +: 8] = b;
    bus.req[i] = 1'b1;
  endtask

  // Frame boundary: pick the frame content from the rules and the sampled requests.
  task automatic model_edge();
    int ph;
    int c;
    if (in_reset) return;
    t++;
    ph = (t + 7) % 8;
    if (ph == 0) begin
      frame_no++;
      m_valid = 1'b0;
      m_byte  = IDLE;
      if (frame_no > TF) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (bus.req[c]) begin
            m_valid = 1'b1;
            m_byte  = bus.data_in[8*c +: 8];
            m_lane  = c;
            m_ptr   = c;
            exp_q.push_back({3'(c), m_byte});
            break;
          end
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, ".data_out"}, 32'(bus.data_out), 0);
    chk({name, ".valid_out"}, 32'(bus.valid_out), 0);
    chk({name, ".ack"}, 32'(bus.ack), 0);
    chk({name, ".frame_start"}, 32'(bus.frame_start), 0);
    chk({name, ".lane_id"}, 32'(bus.lane_id), 0);
    chk({name, ".state"}, 32'(bus.state_dbg), 32'(ST_TRAIN));
  endtask

  task automatic check_outputs();
    int ph;
    logic [N-1:0] ack_e;
    if (t == 0) begin
      check_reset_outputs("post_release");
      return;
    end
    ph    = (t + 7) % 8;
    ack_e = '0;
    if (ph == 0 && m_valid) ack_e[m_lane] = 1'b1;
    chk("data_out", 32'(bus.data_out), 32'(m_byte[7-ph]));
    chk("frame_start", 32'(bus.frame_start), 32'(ph == 0));
    chk("valid_out", 32'(bus.valid_out), 32'(m_valid));
    chk("lane_id", 32'(bus.lane_id), 32'(m_lane));
    chk("ack", 32'(bus.ack), 32'(ack_e));
    chk("state", 32'(bus.state_dbg), (frame_no >= TF) ? 32'(ST_ACTIVE) : 32'(ST_TRAIN));
  endtask

  // Rebuild whole frames from the serial stream and log them.
  task automatic capture();
    if (t == 0) return;
    if (bus.frame_start) begin
      cap_n     = 0;
      cap_byte  = '0;
      cap_valid = bus.valid_out;
      cap_lane  = int'(bus.lane_id);
    end
    if (cap_n >= 0) begin
      cap_byte = {cap_byte[6:0], bus.data_out};
      cap_n++;
      if (cap_n == 8) begin
        log_byte.push_back(cap_byte);
        log_valid.push_back(cap_valid);
        log_lane.push_back(cap_lane);
        if (cap_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got lane %0d byte %0h, expected no data frame", cap_lane, cap_byte);
          end else begin
            chk("sb_frame", {21'b0, 3'(cap_lane), cap_byte}, {21'b0, exp_q.pop_front()});
          end
        end
        cap_n = -1;
      end
    end
  endtask

  task automatic requester_update();
    for (int i = 0; i < N; i++) begin
      if (bus.ack[i]) begin
        ack_seen[i]++;
        if (r_left[i] > 0) r_left[i]--;
        if (r_left[i] == 0) begin
          bus.req[i] = 1'b0;
        end else begin
          r_byte[i] = (r_delta[i] < 0) ? 8'($urandom_range(0, 255)) : r_byte[i] + 8'(r_delta[i]);
          bus.data_in[8*i +: 8] = r_byte[i];
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk_8f);
    model_edge();
    @(negedge clk_8f);
    check_outputs();
    capture();
    requester_update();
  endtask

  task automatic release_reset();
    reset    = 1'b1;
    t        = 0;
    frame_no = 0;
    m_byte   = 8'h00;
    m_valid  = 1'b0;
    m_lane   = 0;
    m_ptr    = N - 1;
    in_reset = 1'b0;
    #1;
    check_outputs();
  endtask

  // Called just after a falling edge so the assertion lands mid-cycle.
  task automatic do_reset_async(input int hold);
    #2 reset = 1'b0;
    #1;
    in_reset = 1'b1;
    check_reset_outputs("rst_async");
    exp_q.delete();
    cap_n = -1;
    repeat (hold) @(negedge clk_8f);
    check_reset_outputs("rst_hold");
    release_reset();
  endtask

  task automatic run_until(input int target, input string name);
    int budget;
    budget = (target - log_byte.size()) * 8 + 24;
    while (log_byte.size() < target && budget > 0) begin
      cycle();
      budget--;
    end
    if (log_byte.size() < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d frames expected %0d", name, log_byte.size(), target);
    end
  endtask

  task automatic wait_ph(input int k);
    int n;
    n = 0;
    while (!(t > 0 && (t + 7) % 8 == k) && n < 10) begin
      cycle();
      n++;
    end
    if (!(t > 0 && (t + 7) % 8 == k)) begin
      checks++;
      errors++;
      $display("FAIL wait_ph: got ph %0d expected %0d", (t + 7) % 8, k);
    end
  endtask

  function automatic void lit(input bit v, input int l, input logic [7:0] b);
    lit_valid.push_back(v);
    lit_lane.push_back(l);
    lit_byte.push_back(b);
  endfunction

  task automatic check_lit(input string name, input int start);
    for (int k = 0; k < lit_byte.size(); k++) begin
      if (start + k >= log_byte.size()) begin
        checks++;
        errors++;
        $display("FAIL %s[%0d]: got no frame expected byte %0h", name, k, lit_byte[k]);
      end else begin
        chk($sformatf("%s[%0d].valid", name, k), 32'(log_valid[start+k]), 32'(lit_valid[k]));
        chk($sformatf("%s[%0d].lane", name, k), 32'(log_lane[start+k]), 32'(lit_lane[k]));
        chk($sformatf("%s[%0d].byte", name, k), 32'(log_byte[start+k]), 32'(lit_byte[k]));
      end
    end
    lit_valid.delete();
    lit_lane.delete();
    lit_byte.delete();
  endtask

  task automatic random_stim();
    for (int i = 0; i < N; i++) begin
      if (!bus.req[i]) begin
        if ($urandom_range(0, 7) == 0)
          start_req(i, 8'($urandom_range(0, 255)), int'($urandom_range(1, 4)), -1);
      end else if ($urandom_range(0, 63) == 0) begin
        bus.req[i] = 1'b0;
        r_left[i]  = 0;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int t_set;
    int n;
    bus.req     = '0;
    bus.data_in = '0;
    for (int i = 0; i < N; i++) begin
      r_byte[i]   = '0;
      r_left[i]   = 0;
      r_delta[i]  = 0;
      ack_seen[i] = 0;
    end
    repeat (2) @(negedge clk_8f);
    check_reset_outputs("rst_power");
    release_reset();

    // Single requester, byte incremented on each ack; two training frames first.
    start_req(0, 8'h01, 3, 1);
    base = log_byte.size();
    run_until(base + 6, "single");
    lit(0, 0, IDLE); lit(0, 0, IDLE);
    lit(1, 0, 8'h01); lit(1, 0, 8'h02); lit(1, 0, 8'h03);
    lit(0, 0, IDLE);
    check_lit("single", base);
    chk("single_acks", 32'(ack_seen[0]), 3);

    // Idle fill.
    base = log_byte.size();
    run_until(base + 3, "idle");
    lit(0, 0, IDLE); lit(0, 0, IDLE); lit(0, 0, IDLE);
    check_lit("idle", base);

    // Reset mid-frame with all four requesting, then round-robin.
    repeat (3) cycle();
    for (int i = 0; i < N; i++) ack_seen[i] = 0;
    start_req(0, 8'hA0, 2, 0);
    start_req(1, 8'hA1, 1, 0);
    start_req(2, 8'hA2, 1, 0);
    start_req(3, 8'hA3, 1, 0);
    do_reset_async(3);
    base = log_byte.size();
    run_until(base + 8, "rr");
    lit(0, 0, IDLE); lit(0, 0, IDLE);
    lit(1, 0, 8'hA0); lit(1, 1, 8'hA1); lit(1, 2, 8'hA2); lit(1, 3, 8'hA3); lit(1, 0, 8'hA0);
    lit(0, 0, IDLE);
    check_lit("rr", base);
    chk("rr_acks0", 32'(ack_seen[0]), 2);
    chk("rr_acks1", 32'(ack_seen[1]), 1);
    chk("rr_acks3", 32'(ack_seen[3]), 1);

    // Pulsed request dropped before the boundary, then a late request at ph=3.
    for (int i = 0; i < N; i++) ack_seen[i] = 0;
    wait_ph(2);
    start_req(1, 8'h55, 1, 0);
    wait_ph(6);
    bus.req[1] = 1'b0;
    r_left[1]  = 0;
    wait_ph(3);
    base = log_byte.size();
    start_req(2, 8'hC7, 1, 0);
    t_set = t;
    n = 0;
    cycle();
    while (!bus.frame_start && n < 10) begin
      cycle();
      n++;
    end
    chk("late_latency", 32'(t - t_set), 5);
    chk("late_msb", 32'(bus.data_out), 1);
    chk("late_lane", 32'(bus.lane_id), 2);
    chk("late_ack", 32'(bus.ack), 32'b0100);
    run_until(base + 2, "late");
    lit(0, 0, IDLE); lit(1, 2, 8'hC7);
    check_lit("late", base);
    chk("pulse_never_acked", 32'(ack_seen[1]), 0);

    // Two requesters alternate; lane 2 continues alone once lane 0 stops.
    start_req(0, 8'h10, 2, 1);
    start_req(2, 8'h20, 5, 1);
    base = log_byte.size();
    run_until(base + 9, "mixed");
    lit(1, 0, 8'h10); lit(1, 2, 8'h20); lit(1, 0, 8'h11); lit(1, 2, 8'h21);
    lit(1, 2, 8'h22); lit(1, 2, 8'h23); lit(1, 2, 8'h24);
    lit(0, 2, IDLE); lit(0, 2, IDLE);
    check_lit("mixed", base);

    // Random traffic with one reset in the middle.
    for (int c = 0; c < RAND_CYCLES; c++) begin
      random_stim();
      cycle();
      if (c == RAND_CYCLES / 2) do_reset_async(int'($urandom_range(1, 4)));
    end
    bus.req = '0;
    for (int i = 0; i < N; i++) r_left[i] = 0;
    run_until(log_byte.size() + 4, "drain");
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
